// File: rtl/bullet_pool.sv
// Multi-slot projectile pool: frame-tick movement, lowest-free-slot spawning, fire cooldown, collision kills.
// Optional BULLET_POOL_EDGE_FIRE_EN: fire only on a rising edge of attack sampled on ticks.
module bullet_pool #(
  parameter int N_SLOTS  = 4,
  parameter int X_W      = 11,
  parameter int Y_W      = 10,
  parameter int MAX_X    = 1279,
  parameter int STEP_X   = 8,
  parameter int COOLDOWN = 6
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          tick,
  input  logic                                          attack,
  input  logic                                          defend,
  input  logic [X_W-1:0]                                xPlayer,
  input  logic [Y_W-1:0]                                yPlayer,
  input  logic                                          facePlayer,
  input  logic                                          hit_valid,
  input  logic [(N_SLOTS > 1 ? $clog2(N_SLOTS) : 1)-1:0] hit_idx,
  output logic [N_SLOTS*X_W-1:0]                        x,
  output logic [N_SLOTS*Y_W-1:0]                        y,
  output logic [N_SLOTS-1:0]                            isE,
  output logic [N_SLOTS-1:0]                            face,
  output logic                                          fire_ack,
  output logic                                          full,
  output logic [$clog2(N_SLOTS+1)-1:0]                  live_count
);
  localparam int HI_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int LC_W = $clog2(N_SLOTS+1);
  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN+1) : 1;

  logic [N_SLOTS-1:0][X_W-1:0] r_x;
  logic [N_SLOTS-1:0][Y_W-1:0] r_y;
  logic [N_SLOTS-1:0]          r_isE, r_face;
  logic [CD_W-1:0]             r_cd;
  logic                        r_ack;

  logic [N_SLOTS-1:0][X_W-1:0] w_nx;
  logic [N_SLOTS-1:0]          w_ret, w_hit;
  logic [HI_W-1:0]             w_free_idx;
  logic                        w_has_free, w_edge, w_fire;
  logic [LC_W-1:0]             w_cnt;

`ifdef BULLET_POOL_EDGE_FIRE_EN
  logic r_atk_q;
  assign w_edge = attack & ~r_atk_q;
`else
  assign w_edge = 1'b1;
`endif

  // Lowest free slot from the registered live mask; slots freed this cycle are not yet visible.
  always_comb begin
    w_free_idx = '0;
    w_has_free = 1'b0;
    for (int i = N_SLOTS-1; i >= 0; i--) begin
      if (!r_isE[i]) begin
        w_free_idx = HI_W'(i);
        w_has_free = 1'b1;
      end
    end
  end

  // Next position and retire test; the x+STEP sum is widened by a bit so it cannot wrap.
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      w_hit[i] = hit_valid && (int'(hit_idx) == i);
      if (r_face[i]) begin
        w_ret[i] = ({1'b0, r_x[i]} + (X_W+1)'(STEP_X)) > (X_W+1)'(MAX_X);
        w_nx[i]  = r_x[i] + X_W'(STEP_X);
      end else begin
        w_ret[i] = r_x[i] < X_W'(STEP_X);
        w_nx[i]  = r_x[i] - X_W'(STEP_X);
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) w_cnt = w_cnt + LC_W'(r_isE[i]);
  end

  assign w_fire = tick && attack && !defend && (r_cd == '0) && w_has_free && w_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_isE  <= '0;
      r_face <= '0;
      r_cd   <= '0;
      r_ack  <= 1'b0;
`ifdef BULLET_POOL_EDGE_FIRE_EN
      r_atk_q <= 1'b0;
`endif
    end else begin
      r_ack <= w_fire;
      for (int i = 0; i < N_SLOTS; i++) begin
        if (w_hit[i]) r_isE[i] <= 1'b0;
        else if (tick && r_isE[i]) begin
          if (w_ret[i]) r_isE[i] <= 1'b0;
          else          r_x[i]   <= w_nx[i];
        end
      end
      // Spawn slot was dead, so it never collides with the movement update above.
      if (w_fire) begin
        r_isE[w_free_idx]  <= 1'b1;
        r_x[w_free_idx]    <= xPlayer;
        r_y[w_free_idx]    <= yPlayer;
        r_face[w_free_idx] <= facePlayer;
        r_cd               <= CD_W'(COOLDOWN);
      end else if (tick && r_cd != '0) begin
        r_cd <= r_cd - CD_W'(1);
      end
`ifdef BULLET_POOL_EDGE_FIRE_EN
      if (tick) r_atk_q <= attack;
`endif
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign isE        = r_isE;
  assign face       = r_face;
  assign fire_ack   = r_ack;
  assign full       = &r_isE;
  assign live_count = w_cnt;
endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: hand-computed vector table, directed corner sequences,
// and random traffic against a slot-array reference model.
module tb_bullet_pool;
  localparam int N = 4, XW = 11, YW = 10, MAXX = 1279, STEP = 8, CD = 6;

  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, attack = 1'b0, defend = 1'b0;
  logic facePlayer = 1'b0, hit_valid = 1'b0;
  logic [XW-1:0] xPlayer = '0;
  logic [YW-1:0] yPlayer = '0;
  logic [1:0]    hit_idx = '0;
  logic [N*XW-1:0] x;
  logic [N*YW-1:0] y;
  logic [N-1:0]    isE, face;
  logic            fire_ack, full;
  logic [2:0]      live_count;

  bullet_pool #(.N_SLOTS(N), .X_W(XW), .Y_W(YW), .MAX_X(MAXX), .STEP_X(STEP), .COOLDOWN(CD)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .attack(attack), .defend(defend),
    .xPlayer(xPlayer), .yPlayer(yPlayer), .facePlayer(facePlayer),
    .hit_valid(hit_valid), .hit_idx(hit_idx),
    .x(x), .y(y), .isE(isE), .face(face), .fire_ack(fire_ack), .full(full), .live_count(live_count));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int mx[N], my[N], mf[N], me[N];
  int mcd, mack, matkq;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin mx[i] = 0; my[i] = 0; mf[i] = 0; me[i] = 0; end
    mcd = 0; mack = 0; matkq = 0;
  endtask

  // Apply one cycle of inputs, advance the model by the block's rules, compare everything.
  task automatic step(input logic r, input logic t, input logic a, input logic d, input int xp,
                      input int yp, input logic fp, input logic hv, input int hi);
    int fr, cnt;
    bit fire;
    logic [63:0] ex, ey, ee, ef;
    rst_n = r; tick = t; attack = a; defend = d;
    xPlayer = XW'(xp); yPlayer = YW'(yp); facePlayer = fp; hit_valid = hv; hit_idx = 2'(hi);
    if (!r) model_clear();
    else begin
      fr = -1;
      for (int i = N-1; i >= 0; i--) if (me[i] == 0) fr = i;
      fire = t && a && !d && mcd == 0 && fr >= 0;
`ifdef BULLET_POOL_EDGE_FIRE_EN
      fire = fire && !matkq;
`endif
      for (int i = 0; i < N; i++) begin
        if (hv && hi == i) me[i] = 0;
        else if (t && me[i] == 1) begin
          if (mf[i] == 1) begin
            if (mx[i] + STEP > MAXX) me[i] = 0; else mx[i] = mx[i] + STEP;
          end else begin
            if (mx[i] < STEP) me[i] = 0; else mx[i] = mx[i] - STEP;
          end
        end
      end
      if (fire) begin
        me[fr] = 1; mx[fr] = xp; my[fr] = yp; mf[fr] = fp; mcd = CD;
      end else if (t && mcd > 0) mcd--;
      mack = fire;
      if (t) matkq = a;
    end
    @(posedge clk); #1;
    ex = '0; ey = '0; ee = '0; ef = '0; cnt = 0;
    for (int i = 0; i < N; i++) begin
      ex[i*XW +: XW] = XW'(mx[i]);
      ey[i*YW +: YW] = YW'(my[i]);
      ee[i] = me[i][0];
      ef[i] = mf[i][0];
      cnt += me[i];
    end
    chk("x", 64'(x), ex);
    chk("y", 64'(y), ey);
    chk("isE", 64'(isE), ee);
    chk("face", 64'(face), ef);
    chk("fire_ack", 64'(fire_ack), 64'(mack));
    chk("full", 64'(full), 64'(cnt == N));
    chk("live_count", 64'(live_count), 64'(cnt));
  endtask

  typedef struct {
    logic t, a, d; int xp; logic fp, hv; int hi;
    logic [3:0] e_isE; logic e_ack; int e_x0;
  } vec_t;
  vec_t tbl[13];

  int shots[$];
  int exp_shots[$];

  initial begin
    tbl[0]  = '{1,1,0,100,1,0,0, 4'b0001,1,100};
    tbl[1]  = '{1,0,0,  0,1,0,0, 4'b0001,0,108};
    tbl[2]  = '{0,0,0,  0,1,0,0, 4'b0001,0,108};
    tbl[3]  = '{1,0,0,  0,1,0,0, 4'b0001,0,116};
    tbl[4]  = '{1,0,0,  0,1,0,0, 4'b0001,0,124};
    tbl[5]  = '{0,0,0,  0,0,1,0, 4'b0000,0,124};
    tbl[6]  = '{1,0,0,  0,0,0,0, 4'b0000,0,124};
    tbl[7]  = '{1,0,0,  0,0,0,0, 4'b0000,0,124};
    tbl[8]  = '{1,0,0,  0,0,0,0, 4'b0000,0,124};
    tbl[9]  = '{1,1,1,  5,0,0,0, 4'b0000,0,124};
    tbl[10] = '{1,0,0,  5,0,0,0, 4'b0000,0,124};
    tbl[11] = '{1,1,0,  5,0,0,0, 4'b0001,1,5};
    tbl[12] = '{1,0,0,  0,0,0,0, 4'b0000,0,5};

    // Reset and idle
    step(0,1,1,0,50,50,1,1,0);
    step(0,1,1,0,50,50,1,1,0);
    chk("rst_isE", 64'(isE), 64'd0);
    chk("rst_live", 64'(live_count), 64'd0);
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_ack", 64'(fire_ack), 64'd0);
    for (int k = 0; k < 3; k++) step(1,1,0,0,0,0,0,0,0);
    chk("idle_isE", 64'(isE), 64'd0);

    // Hand-computed table: single shot, hit kill, defend, retire at x=5
    for (int k = 0; k < 13; k++) begin
      step(1, tbl[k].t, tbl[k].a, tbl[k].d, tbl[k].xp, 7, tbl[k].fp, tbl[k].hv, tbl[k].hi);
      chk($sformatf("tbl%0d_isE", k), 64'(isE), 64'(tbl[k].e_isE));
      chk($sformatf("tbl%0d_ack", k), 64'(fire_ack), 64'(tbl[k].e_ack));
      chk($sformatf("tbl%0d_x0", k), 64'(x[XW-1:0]), 64'(tbl[k].e_x0));
    end

    // +x spawn at 1275 retires next tick without wrapping
    for (int k = 0; k < 6; k++) step(1,1,0,0,0,0,0,0,0);
    step(1,1,1,0,1275,3,1,0,0);
    chk("hi_spawn_x0", 64'(x[XW-1:0]), 64'd1275);
    step(1,1,0,0,0,0,0,0,0);
    chk("hi_ret_isE", 64'(isE), 64'd0);
    chk("hi_ret_x0", 64'(x[XW-1:0]), 64'd1275);

    // Attack held 30 ticks from a clean state
    step(0,0,0,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 30; k++) begin
      step(1,1,1,0,100,50,1,0,0);
      if (fire_ack) shots.push_back(k);
    end
`ifdef BULLET_POOL_EDGE_FIRE_EN
    exp_shots = '{0};
`else
    exp_shots = '{0, 7, 14, 21};
`endif
    chk("shot_count", 64'(shots.size()), 64'(exp_shots.size()));
    for (int k = 0; k < shots.size() && k < exp_shots.size(); k++)
      chk($sformatf("shot%0d_tick", k), 64'(shots[k]), 64'(exp_shots[k]));
`ifndef BULLET_POOL_EDGE_FIRE_EN
    chk("fill_full", 64'(full), 64'd1);
    // Kill slot 2 on a non-tick cycle, next shot reuses it
    step(1,0,1,0,0,0,0,1,2);
    chk("kill_isE", 64'(isE), 64'b1011);
    step(1,1,1,0,200,9,0,0,0);
    chk("reuse_ack", 64'(fire_ack), 64'd1);
    chk("reuse_isE", 64'(isE), 64'b1111);
    chk("reuse_x2", 64'(x[2*XW +: XW]), 64'd200);
`endif

    // Kill and retirement of the same slot on one tick
    step(0,0,0,0,0,0,0,0,0);
    step(1,1,1,0,3,4,0,0,0);
    chk("kr_spawn", 64'(isE), 64'b0001);
    step(1,1,0,0,0,0,0,1,0);
    chk("kr_isE", 64'(isE), 64'd0);
    chk("kr_x0", 64'(x[XW-1:0]), 64'd3);
    chk("kr_live", 64'(live_count), 64'd0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int xp;
      case ($urandom_range(0, 3))
        0:       xp = $urandom_range(0, 12);
        1:       xp = $urandom_range(1266, 1279);
        default: xp = $urandom_range(0, 1279);
      endcase
      step(($urandom_range(0, 299) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, xp, $urandom_range(0, 1023), $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
